// File: rtl/seven_segment_scan.sv
// Multiplexed hex seven-segment scanner with shadowed display data and a registered pin stage.
// Optional leading-zero blanking is built only when SEVEN_SEGMENT_SCAN_LZB_EN is defined.
module seven_segment_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] val_sh;
  logic [NUM_DIGITS-1:0]   dp_sh;
  logic                    tick;

  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_log;
  logic [6:0]              seg_log;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b0111111;
      4'h1: decode = 7'b0000110;
      4'h2: decode = 7'b1011011;
      4'h3: decode = 7'b1001111;
      4'h4: decode = 7'b1100110;
      4'h5: decode = 7'b1101101;
      4'h6: decode = 7'b1111101;
      4'h7: decode = 7'b0000111;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1101111;
      4'hA: decode = 7'b1110111;
      4'hB: decode = 7'b1111100;
      4'hC: decode = 7'b0111001;
      4'hD: decode = 7'b1011110;
      4'hE: decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  // The scan only advances while enabled, so a disabled display resumes where it froze.
  assign tick = enable && (cnt == CNT_LAST);

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    logic run;
    run       = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run          = run && (val_sh[4*i +: 4] == 4'h0);
      lead_zero[i] = run;
    end
  end
`endif

  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    an_log = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = val_sh[4*i +: 4];
        dp_sel    = dp_sh[i];
        an_log[i] = 1'b1;
`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
        blank     = (i > 0) && lead_zero[i];
`endif
      end
    end
    seg_log = blank ? 7'b0000000 : decode(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      idx    <= '0;
      val_sh <= '0;
      dp_sh  <= '0;
    end else begin
      if (load) begin
        val_sh <= value;
        dp_sh  <= dp_in;
      end
      if (enable) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
      if (tick) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end
    end
  end

  // Pin stage: polarity is folded in last so every logical decision above stays active-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
      dp  <= ACTIVE_LOW;
    end else if (enable) begin
      seg <= seg_log ^ SEG_OFF;
      an  <= an_log ^ AN_OFF;
      dp  <= dp_sel ^ ACTIVE_LOW;
    end else begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
      dp  <= ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed table-driven bench for seven_segment_scan (4 digits, 4-clock slots), checking an
// active-high and an active-low instance side by side from the same stimulus.
module tb_seven_segment_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        enable;
  logic [6:0]  seg_h, seg_l;
  logic [3:0]  an_h, an_l;
  logic        dp_h, dp_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b0)) dut_h (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
    .seg(seg_h), .an(an_h), .dp(dp_h)
  );

  seven_segment_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)) dut_l (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in), .enable(enable),
    .seg(seg_l), .an(an_l), .dp(dp_l)
  );

  localparam logic [6:0] OFF = 7'b0000000;
  localparam logic [6:0] S0  = 7'b0111111;
  localparam logic [6:0] S1  = 7'b0000110;
  localparam logic [6:0] S2  = 7'b1011011;
  localparam logic [6:0] S4  = 7'b1100110;
  localparam logic [6:0] S5  = 7'b1101101;
  localparam logic [6:0] S7  = 7'b0000111;
  localparam logic [6:0] SA  = 7'b1110111;
  localparam logic [6:0] SF  = 7'b1110001;
  // A zero digit that sits in the leading-zero run (digit index > 0).
`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
  localparam logic [6:0] ZL  = 7'b0000000;
`else
  localparam logic [6:0] ZL  = S0;
`endif

  typedef struct {
    logic        rst;
    logic        load;
    logic        en;
    logic [15:0] value;
    logic [3:0]  dpi;
    int          n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic l, input logic e, input logic [15:0] v,
                              input logic [3:0] d, input int n, input logic [6:0] s,
                              input logic [3:0] a, input logic p);
    vec_t t;
    t.rst = r; t.load = l; t.en = e; t.value = v; t.dpi = d; t.n = n;
    t.seg = s; t.an = a; t.dp = p;
    return t;
  endfunction

  // Holds the row's inputs for n rising edges and checks both instances after each edge.
  task automatic run_row(input vec_t v, input string tag);
    logic [11:0] want;
    rst    = v.rst;
    load   = v.load;
    enable = v.en;
    value  = v.value;
    dp_in  = v.dpi;
    want   = {v.seg, v.an, v.dp};
    for (int c = 0; c < v.n; c++) begin
      @(negedge clk);
      total_cnt++;
      if ({seg_h, an_h, dp_h} === want) pass_cnt++;
      else $display("FAIL %s cyc%0d active_high: seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b",
                    tag, c, seg_h, an_h, dp_h, v.seg, v.an, v.dp);
      total_cnt++;
      if ({seg_l, an_l, dp_l} === ~want) pass_cnt++;
      else $display("FAIL %s cyc%0d active_low: seg=%b an=%b dp=%b expected seg=%b an=%b dp=%b",
                    tag, c, seg_l, an_l, dp_l, ~v.seg, ~v.an, ~v.dp);
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; enable = 1'b0; value = '0; dp_in = '0;

    // Reset, then load 12AF and watch a full scan plus wrap.
    tbl.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 2, OFF, 4'b0000, 0));
    tbl.push_back(mk(0, 1, 1, 16'h12AF, 4'b0000, 1, S0,  4'b0001, 0));
    tbl.push_back(mk(0, 0, 1, 16'h12AF, 4'b0000, 3, SF,  4'b0001, 0));
    tbl.push_back(mk(0, 0, 1, 16'h12AF, 4'b0000, 4, SA,  4'b0010, 0));
    tbl.push_back(mk(0, 0, 1, 16'h12AF, 4'b0000, 4, S2,  4'b0100, 0));
    tbl.push_back(mk(0, 0, 1, 16'h12AF, 4'b0000, 4, S1,  4'b1000, 0));
    tbl.push_back(mk(0, 0, 1, 16'h12AF, 4'b0000, 4, SF,  4'b0001, 0));
    // All-zero value with a decimal point on digit 2.
    tbl.push_back(mk(0, 1, 1, 16'h0000, 4'b0100, 1, SA,  4'b0010, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 4'b0100, 3, ZL,  4'b0010, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 4'b0100, 4, ZL,  4'b0100, 1));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 4'b0100, 4, ZL,  4'b1000, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 4'b0100, 4, S0,  4'b0001, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 4'b0100, 4, ZL,  4'b0010, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0000, 4'b0100, 2, ZL,  4'b0100, 1));
    // Disable at digit 2 for 10 clocks while loading FFFF, then resume mid-slot.
    tbl.push_back(mk(0, 1, 0, 16'hFFFF, 4'b0000, 1, OFF, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 16'hFFFF, 4'b0000, 9, OFF, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 16'hFFFF, 4'b0000, 2, SF,  4'b0100, 0));
    tbl.push_back(mk(0, 0, 1, 16'hFFFF, 4'b0000, 4, SF,  4'b1000, 0));

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("vec%0d", i));

    // Load coincident with a tick: the first output at the new index must show the new data.
    run_row(mk(0, 1, 1, 16'h1234, 4'b0000, 1, SF,  4'b0001, 0), "tick_load_a");
    run_row(mk(0, 0, 1, 16'h1234, 4'b0000, 2, S4,  4'b0001, 0), "tick_load_b");
    run_row(mk(0, 1, 1, 16'h5678, 4'b0000, 1, S4,  4'b0001, 0), "tick_load_c");
    run_row(mk(0, 0, 1, 16'h5678, 4'b0000, 2, S7,  4'b0010, 0), "tick_load_d");

    // Reset mid-scan discards the shadow and restarts at digit 0 with a fresh slot.
    run_row(mk(1, 1, 1, 16'h5678, 4'b1111, 1, OFF, 4'b0000, 0), "mid_rst");
    run_row(mk(0, 0, 1, 16'h5678, 4'b1111, 4, S0,  4'b0001, 0), "post_rst_d0");
    run_row(mk(0, 0, 1, 16'h5678, 4'b1111, 1, ZL,  4'b0010, 0), "post_rst_d1");

`ifdef SEVEN_SEGMENT_SCAN_LZB_EN
    run_row(mk(0, 1, 1, 16'h0050, 4'b0000, 1, OFF, 4'b0010, 0), "lzb_load");
    run_row(mk(0, 0, 1, 16'h0050, 4'b0000, 2, S5,  4'b0010, 0), "lzb_d1");
    run_row(mk(0, 0, 1, 16'h0050, 4'b0000, 4, OFF, 4'b0100, 0), "lzb_d2");
    run_row(mk(0, 0, 1, 16'h0050, 4'b0000, 4, OFF, 4'b1000, 0), "lzb_d3");
    run_row(mk(0, 0, 1, 16'h0050, 4'b0000, 4, S0,  4'b0001, 0), "lzb_d0");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan.md
SEVEN_SEGMENT_SCAN -- requirements
Module: seven_segment_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, meaning number of multiplexed hex digits; legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per digit slot; legal range 2..2^20.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0, meaning 1 inverts seg, an and dp at the pins.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load  input  1  capture strobe for value and dp_in.
REQ-007 SHALL have port value  input  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, digit 0 least significant.
REQ-008 SHALL have port dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-009 SHALL have port enable  input  1  1 = scanning; 0 = display blanked and scan frozen.
REQ-010 SHALL have port seg  output  7  segments, bit0=a ... bit6=g, registered.
REQ-011 SHALL have port an  output  NUM_DIGITS  one-hot digit select, registered.
REQ-012 SHALL have port dp  output  1  decimal point for the selected digit, registered.

Function
REQ-013 SHALL keep a prescaler counting 0..REFRESH_DIV-1; on reaching REFRESH_DIV-1 it returns to 0 and asserts an internal tick for that cycle.
REQ-014 SHALL advance the digit index by 1 on each tick, wrapping NUM_DIGITS-1 -> 0; with NUM_DIGITS=1 the index stays 0.
REQ-015 SHALL capture value and dp_in into shadow registers on any cycle with load=1; the display uses only shadow data, never live inputs.
REQ-016 SHALL, when load and tick coincide, update both the shadow and the index on the same edge; the next registered output uses the new index with the new data.
REQ-017 SHALL register seg/an/dp from the current index and shadow data: one-cycle latency from any index or shadow change to the pins.
REQ-018 SHALL decode nibbles (logical, 1=lit, gfedcba): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-019 SHALL drive an logical one-hot with bit index = digit index while enable=1.
REQ-020 SHALL, while enable=0, hold prescaler and index, drive an, seg and dp logically all-off (one-cycle latency), and still accept load.
REQ-021 SHALL, on enable rising, resume from the held prescaler and index values.
REQ-022 SHALL apply ACTIVE_LOW inversion after all logical decisions, uniformly to seg, an and dp.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, clear prescaler, index, value shadow and dp shadow to 0.
REQ-024 SHALL drive seg, an and dp logically all-off in the cycle after any reset edge (pin 1s if ACTIVE_LOW=1).
REQ-025 SHALL give rst priority over load, enable and tick; reset mid-scan discards the shadow and restarts at digit 0 with prescaler 0.

Configuration
REQ-026 SHALL provide leading-zero blanking when macro SEVEN_SEGMENT_SCAN_LZB_EN is defined: digit i>0 shows seg logically off when its nibble and all more-significant nibbles are 0; digit 0 is never blanked; an and dp are unaffected.
REQ-027 SHALL, with SEVEN_SEGMENT_SCAN_LZB_EN undefined, display every digit including leading zeros, with no blanking logic present.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0 unless stated)
REQ-028 SHALL cover: rst 2 cycles, then load value=16'h12AF, enable=1 -> an cycles 0001,0010,0100,1000 every 4 clks; seg=1110001,1110111,1011011,0000110 respectively; wraps to 0001.
REQ-029 SHALL cover: load dp_in=4'b0100, value=16'h0000 -> dp=1 only while an=0100; without LZB all digits seg=0111111.
REQ-030 SHALL cover (LZB_EN defined): value=16'h0050 -> digits 3 and 2 seg=0000000, digit 1 seg=1101101, digit 0 seg=0111111; value=16'h0000 -> only digit 0 lit.
REQ-031 SHALL cover: enable=0 at index 2 for 10 clks with load of 16'hFFFF -> an=0000, seg=0000000; on enable=1, scan resumes at digit 2 showing 1110001.
REQ-032 SHALL cover: load coincident with tick, 16'h1234 -> 16'h5678 -> first new-index output shows new data; rst asserted mid-scan -> next cycle all-off, then digit 0 with seg=0111111.
REQ-033 SHALL cover: ACTIVE_LOW=1 rerun of REQ-028 -> every pin bit is the inverse of the stated value, reset pins all 1.
